seq_shift_left: RTL

Multi-cycle logical left shifter for the 16-bit ALU datapath. It is the left-direction counterpart of the existing combinational right barrel shifter. It applies one binary-weighted stage per clock (shift by 1, 2, 4, 8), trading latency for area. It uses valid/ready handshakes on both input and output so it can sit between the operand register file and the ALU result mux with backpressure.

---
 rtl/alu_pkg.sv | 13 +
 rtl/shl_stage.sv | 25 ++
 rtl/seq_shift_left.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and the left-shifter FSM state type.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_SHW   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shl_state_t;

endpackage : alu_pkg

// File: rtl/shl_stage.sv
// One conditional left-shift-by-(1<<K) stage of the sequential shifter.
// Define SEQ_SHL_ROTATE_EN to rotate left instead of shifting with zero fill.
module shl_stage #(
  parameter int WIDTH = 16,
  parameter int K     = 0
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] moved;

`ifdef SEQ_SHL_ROTATE_EN
  // Bits leaving the MSB re-enter at the LSB.
  assign moved = (d << S) | (d >> (WIDTH - S));
`else
  assign moved = d << S;
`endif

  assign q = en ? moved : d;

endmodule : shl_stage

// File: rtl/seq_shift_left.sv
// Multi-cycle left shifter: one binary-weighted stage per clock, valid/ready on both sides.
// Define SEQ_SHL_ROTATE_EN to make every stage a left rotate (handled inside shl_stage).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// the producer holds d_in/shamt/in_valid until in_ready, the result is held until out_ready.
module seq_shift_left
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         d_in,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         d_out,
  output logic                     carry_out,
  output logic                     zero,
  output logic [1:0]               dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam int STW = (SHW > 1) ? $clog2(SHW) : 1;

  shl_state_t       state_q, state_d;
  logic [STW-1:0]   stage_q, stage_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] stage_out [SHW];
  logic [WIDTH-1:0] stage_sel;
  logic [SHW:0]     msb_idx;
  logic             accept_carry;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shl_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .en (shamt_q[k]),
      .d  (data_q),
      .q  (stage_out[k])
    );
  end

  // Shift-amount mux: the stage counter picks which weighted stage applies this cycle.
  always_comb begin
    stage_sel = data_q;
    for (int k = 0; k < SHW; k++) begin
      if (stage_q == STW'(k)) begin
        stage_sel = stage_out[k];
      end
    end
  end

  // Last bit to leave the MSB is d_in[WIDTH-shamt]; in rotate mode that same bit
  // lands in result[0], so one expression serves both builds.
  always_comb begin
    msb_idx      = (SHW + 1)'(WIDTH) - {1'b0, shamt};
    accept_carry = (shamt == '0) ? 1'b0 : d_in[msb_idx[SHW-1:0]];
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = d_in;
          shamt_d = shamt;
          carry_d = accept_carry;
          stage_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d = stage_sel;
        if (stage_q == STW'(SHW - 1)) begin
          stage_d = '0;
          state_d = DONE;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      data_q  <= '0;
      shamt_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    d_out     = data_q;
    carry_out = carry_q;
    zero      = (data_q == '0);
    dbg_state = state_q;
  end

endmodule : seq_shift_left
